mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multicycle control FSM for the MIPS core. It sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback steps, one step per cycle. It supports the same instruction set as the single-cycle decoder: R-type, ADDI, BEQ, J, JAL, SW and LW. It sits between the instruction register opcode field and the multicycle datapath and memory port.

Parameters:
TIMEOUT, 255, max cycles spent waiting for mem_ready in any memory state before aborting (1..65535)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_rd  out  1  memory read request
mem_we  out  1  memory write request
iord  out  1  0 = address from PC, 1 = address from ALUOut
ir_we  out  1  load instruction register
pc_we  out  1  write PC (already includes branch qualification)
pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
reg_dst  out  1  1 = rd, 0 = rt
dm2reg  out  1  writeback from MDR
jal  out  1  writeback $31 with PC
we_reg  out  1  register file write
illegal  out  1  one-cycle pulse on an unsupported opcode
mem_err  out  1  sticky memory timeout flag; cleared only by rst
state  out  4  current state encoding, for debug
instr_cnt  out  CNT_W  retired instructions (optional feature)
cycle_cnt  out  CNT_W  cycles since reset (optional feature)

Behaviour:
- Reset is asynchronous and active-high. It forces state = FETCH, wait counter = 0, mem_err = 0 and both counters = 0.
- Outputs are Moore, decoded from state. Exceptions: ir_we and pc_we are also gated by mem_ready or zero, as listed below. Any output not listed for a state is 0.
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Codes 12..15 are unreachable and recover to FETCH.
- FETCH:
  - Outputs: mem_rd = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_we = pc_we = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
  - Out of reset the outputs are the FETCH decode with mem_ready gating.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (computes branch target).
  - Next state by opcode: 000000 → EXEC; 100011 and 101011 → MEMADR; 000100 → BRANCH; 001000 → ADDIEX; 000010 and 000011 → JUMP.
  - Any other opcode: illegal = 1 for this cycle, next state FETCH, PC not rolled back.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_rd = 1, iord = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: we_reg = 1, dm2reg = 1, reg_dst = 0. Goes to FETCH.
- MEMWR: mem_we = 1, iord = 1. Waits for mem_ready, then goes to FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to ALUWB.
- ALUWB: we_reg = 1, reg_dst = 1. Goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_we = zero.
  - Goes to FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to ADDIWB.
- ADDIWB: we_reg = 1, reg_dst = 0. Goes to FETCH.
- JUMP:
  - Outputs: pc_src = 10, pc_we = 1.
  - For JAL also jal = 1 and we_reg = 1 (same cycle; the datapath writes the old PC+4 to $31).
  - Goes to FETCH.
- Memory wait timeout:
  - The wait counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0, and clears on every state change.
  - On reaching TIMEOUT: mem_err is set, next state is FETCH, and no ir_we, pc_we or we_reg is issued.
  - If mem_ready arrives on the same cycle the counter reaches TIMEOUT, mem_ready wins and no error is raised.
- opcode is sampled only in DECODE and MEMADR. The datapath holds IR stable until the next FETCH handshake.
- Latencies with zero-wait memory:
  - LW 5 cycles; SW, R-type and ADDI 4 cycles; BEQ, J and JAL 3 cycles.
  - Each memory wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately. No partial writeback is issued after rst falls.

Optional Feature:
MC_CTRL_PERF_EN
- Defined:
  - cycle_cnt increments every cycle after reset.
  - instr_cnt increments on each transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP.
  - Illegal and timeout exits do not count.
  - Both counters wrap modulo 2^CNT_W.
- Not defined: instr_cnt and cycle_cnt are driven constant 0, and no counter flops exist.

Decomposition:
- Shared package mc_pkg holds:
  - the state enumeration and 4-bit encodings
  - opcode constants (OP_RTYPE 000000, OP_ADDI 001000, OP_BEQ 000100, OP_J 000010, OP_JAL 000011, OP_LW 100011, OP_SW 101011)
  - alu_op, alu_src_b and pc_src encodings
- One natural sub-module: mc_ctrl_outdec, a pure state-to-control-word decode. The FSM, wait counter and perf counters stay in mc_ctrl_fsm.

Test Plan:
- Reset released with mem_ready = 1, opcode = 100011 → state sequence 0,1,2,3,4,0. we_reg = 1 and dm2reg = 1 in state 4 only. instr_cnt = 1.
- opcode = 000100 with zero = 1, then with zero = 0 → pc_we = 1 and pc_src = 01 in BRANCH, then pc_we = 0. 3 cycles each.
- opcode = 000011 → JUMP cycle has pc_we = 1, pc_src = 10, jal = 1, we_reg = 1. opcode = 000010 gives the same JUMP cycle with jal = 0 and we_reg = 0.
- SW with mem_ready low for 3 cycles in MEMWR → mem_we held for 4 cycles, then FETCH. mem_err stays 0.
- TIMEOUT = 4, mem_ready held 0 in FETCH → mem_err = 1 after 4 wait cycles, ir_we never 1, state stays 0. rst clears mem_err.
- opcode = 111111 → illegal pulses for 1 cycle in DECODE, next state 0. rst asserted in state 3 → state = 0 asynchronously.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state codes,
// supported opcodes and control-field encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       dm2reg;
    logic       jal;
    logic       we_reg;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_JAL, OP_LW, OP_SW: is_supported_op = 1'b1;
      default: is_supported_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state-to-control-word decode for mc_ctrl_fsm. ir_we/pc_we are raw
// requests here; the FSM qualifies them with mem_ready and zero.
module mc_ctrl_outdec
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   jal_sel,
  output ctrl_t  ctrl
);

  // Control word per state; anything not set for a state stays low.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.ir_we     = 1'b1;
        ctrl.pc_we     = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.iord   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.we_reg  = 1'b1;
        ctrl.dm2reg  = 1'b1;
        ctrl.reg_dst = 1'b0;
      end
      ST_MEMWR: begin
        ctrl.mem_we = 1'b1;
        ctrl.iord   = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.we_reg  = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_we     = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl.we_reg  = 1'b1;
        ctrl.reg_dst = 1'b0;
      end
      ST_JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_we  = 1'b1;
        ctrl.jal    = jal_sel;
        ctrl.we_reg = jal_sel;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory-wait timeout. Optional performance
// counters are built only when MC_CTRL_PERF_EN is defined.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             dm2reg,
  output logic             jal,
  output logic             we_reg,
  output logic             illegal,
  output logic             mem_err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] wait_cnt_r;
  logic        mem_err_r;
  logic        jal_sel_r;
  logic        wait_state_s;
  logic        timeout_s;
  logic        illegal_s;
  ctrl_t       ctrl_s;

  assign wait_state_s = (state_r == ST_FETCH) || (state_r == ST_MEMRD) || (state_r == ST_MEMWR);
  // Timeout fires on the TIMEOUT-th consecutive wait cycle; a late mem_ready still wins.
  assign timeout_s    = wait_state_s && !mem_ready && (wait_cnt_r == WAIT_LAST);
  assign illegal_s    = (state_r == ST_DECODE) && !is_supported_op(opcode);

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH:  next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state_s = ST_EXEC;
          OP_LW, OP_SW: next_state_s = ST_MEMADR;
          OP_BEQ:       next_state_s = ST_BRANCH;
          OP_ADDI:      next_state_s = ST_ADDIEX;
          OP_J, OP_JAL: next_state_s = ST_JUMP;
          default:      next_state_s = ST_FETCH;
        endcase
      end
      ST_MEMADR: next_state_s = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (mem_ready)      next_state_s = ST_MEMWB;
        else if (timeout_s) next_state_s = ST_FETCH;
        else                next_state_s = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready || timeout_s) next_state_s = ST_FETCH;
        else                        next_state_s = ST_MEMWR;
      end
      ST_EXEC:   next_state_s = ST_ALUWB;
      ST_ADDIEX: next_state_s = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: next_state_s = ST_FETCH;
      default:   next_state_s = ST_FETCH;
    endcase
  end

  // State, wait counter, sticky error and latched JAL select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= 16'd0;
      mem_err_r  <= 1'b0;
      jal_sel_r  <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      mem_err_r <= mem_err_r | timeout_s;
      if ((next_state_s != state_r) || timeout_s) begin
        wait_cnt_r <= 16'd0;
      end else if (wait_state_s && !mem_ready) begin
        wait_cnt_r <= wait_cnt_r + 16'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (state_r == ST_DECODE) begin
        jal_sel_r <= (opcode == OP_JAL);
      end else begin
        jal_sel_r <= jal_sel_r;
      end
    end
  end

  mc_ctrl_outdec u_outdec (
    .state   (state_r),
    .jal_sel (jal_sel_r),
    .ctrl    (ctrl_s)
  );

  // Qualify the write enables with the memory handshake and branch condition.
  always_comb begin
    ir_we = ctrl_s.ir_we & mem_ready;
    if (state_r == ST_BRANCH) begin
      pc_we = ctrl_s.pc_we & zero;
    end else if (state_r == ST_FETCH) begin
      pc_we = ctrl_s.pc_we & mem_ready;
    end else begin
      pc_we = ctrl_s.pc_we;
    end
  end

  assign mem_rd    = ctrl_s.mem_rd;
  assign mem_we    = ctrl_s.mem_we;
  assign iord      = ctrl_s.iord;
  assign pc_src    = ctrl_s.pc_src;
  assign alu_src_a = ctrl_s.alu_src_a;
  assign alu_src_b = ctrl_s.alu_src_b;
  assign alu_op    = ctrl_s.alu_op;
  assign reg_dst   = ctrl_s.reg_dst;
  assign dm2reg    = ctrl_s.dm2reg;
  assign jal       = ctrl_s.jal;
  assign we_reg    = ctrl_s.we_reg;
  assign illegal   = illegal_s;
  assign mem_err   = mem_err_r;
  assign state     = state_r;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] instr_cnt_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic             retire_s;

  // Illegal and timeout exits are not retirements.
  assign retire_s = (state_r == ST_MEMWB) || (state_r == ST_ALUWB) || (state_r == ST_ADDIWB) ||
                    (state_r == ST_BRANCH) || (state_r == ST_JUMP) ||
                    ((state_r == ST_MEMWR) && mem_ready);

  // Free-running cycle count and retired-instruction count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_r <= '0;
      cycle_cnt_r <= '0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      if (retire_s) begin
        instr_cnt_r <= instr_cnt_r + CNT_W'(1);
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
    end
  end

  assign instr_cnt = instr_cnt_r;
  assign cycle_cnt = cycle_cnt_r;
`else
  assign instr_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed vector table, hand-written
// timeout/reset sequences and a random instruction stream against a trace model.
module tb_mc_ctrl_fsm;

  localparam int TO = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_rd, mem_we, iord, ir_we, pc_we, alu_src_a;
  logic [1:0]    pc_src, alu_src_b, alu_op;
  logic          reg_dst, dm2reg, jal, we_reg, illegal, mem_err;
  logic [3:0]    state;
  logic [CW-1:0] instr_cnt, cycle_cnt;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .dm2reg(dm2reg), .jal(jal), .we_reg(we_reg), .illegal(illegal),
    .mem_err(mem_err), .state(state), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_rd, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       reg_dst, dm2reg, jal, we_reg, illegal;
  } obs_t;

  typedef struct {
    logic       rdy;
    logic       z;
    logic [5:0] op;
    obs_t       exp;
    logic       ret;
    logic       tmo;
  } cyc_t;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    int          mw;
    int          len;
    logic [31:0] trace;
    logic [5:0]  last;
    logic        ret;
  } row_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc_since_rst = 0;
  int   exp_instr = 0;
  logic exp_err = 1'b0;
  cyc_t tq[$];
  logic       cur_z;
  logic [5:0] cur_op;
  logic       cur_jal;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic z, input logic [5:0] op);
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    #2;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc_since_rst++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_since_rst = 0;
    exp_instr = 0;
    exp_err = 1'b0;
  endtask

  task automatic chk_cnt();
`ifdef MC_CTRL_PERF_EN
    chk("cycle_cnt", 64'(cycle_cnt), 64'(cyc_since_rst));
    chk("instr_cnt", 64'(instr_cnt), 64'(exp_instr));
`else
    chk("cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("instr_cnt", 64'(instr_cnt), 64'd0);
`endif
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.st = state; o.mem_rd = mem_rd; o.mem_we = mem_we; o.iord = iord;
    o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.a = alu_src_a;
    o.b = alu_src_b; o.op = alu_op; o.reg_dst = reg_dst; o.dm2reg = dm2reg;
    o.jal = jal; o.we_reg = we_reg; o.illegal = illegal;
    return o;
  endfunction

  // Control values each step must show, straight from the step descriptions.
  function automatic obs_t exp_obs(input int st, input logic rdy, input logic z,
                                   input logic isjal, input logic ill);
    obs_t o = '0;
    o.st = 4'(st);
    case (st)
      0:  begin o.mem_rd = 1'b1; o.b = 2'b01; o.ir_we = rdy; o.pc_we = rdy; end
      1:  begin o.b = 2'b11; o.illegal = ill; end
      2:  begin o.a = 1'b1; o.b = 2'b10; end
      3:  begin o.mem_rd = 1'b1; o.iord = 1'b1; end
      4:  begin o.we_reg = 1'b1; o.dm2reg = 1'b1; end
      5:  begin o.mem_we = 1'b1; o.iord = 1'b1; end
      6:  begin o.a = 1'b1; o.op = 2'b10; end
      7:  begin o.we_reg = 1'b1; o.reg_dst = 1'b1; end
      8:  begin o.a = 1'b1; o.op = 2'b01; o.pc_src = 2'b01; o.pc_we = z; end
      9:  begin o.a = 1'b1; o.b = 2'b10; end
      10: begin o.we_reg = 1'b1; end
      11: begin o.pc_src = 2'b10; o.pc_we = 1'b1; o.jal = isjal; o.we_reg = isjal; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic void add(input int st, input logic rdy, input logic ret,
                              input logic tmo, input logic ill);
    cyc_t c;
    c.rdy = rdy; c.z = cur_z; c.op = cur_op; c.ret = ret; c.tmo = tmo;
    c.exp = exp_obs(st, rdy, cur_z, cur_jal, ill);
    tq.push_back(c);
  endfunction

  // Expected per-cycle trace of one instruction given its memory wait counts.
  task automatic build_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
    logic legal;
    cur_op = op; cur_z = z; cur_jal = (op == 6'b000011);
    legal = (op == 6'b000000) || (op == 6'b001000) || (op == 6'b000100) || (op == 6'b000010) ||
            (op == 6'b000011) || (op == 6'b100011) || (op == 6'b101011);
    for (int i = 0; i < wf; i++) add(0, 1'b0, 1'b0, i == TO - 1, 1'b0);
    if (wf >= TO) return;
    add(0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, !legal);
    if (!legal) return;
    case (op)
      6'b100011, 6'b101011: begin
        add(2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < wm; i++) add(op[3] ? 5 : 3, 1'b0, 1'b0, i == TO - 1, 1'b0);
        if (wm >= TO) return;
        if (op[3]) begin
          add(5, 1'b1, 1'b1, 1'b0, 1'b0);
        end else begin
          add(3, 1'b1, 1'b0, 1'b0, 1'b0);
          add(4, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        end
      end
      6'b000000: begin
        add(6, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        add(7, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      end
      6'b001000: begin
        add(9, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        add(10, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      end
      6'b000100: add(8, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      default:   add(11, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    endcase
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t rows[9];
    logic [5:0] ops[11];
    rows[0] = '{6'b100011, 1'b0, 0, 5, 32'h00043210, 6'b000010, 1'b1};
    rows[1] = '{6'b000100, 1'b1, 0, 3, 32'h00000810, 6'b101000, 1'b1};
    rows[2] = '{6'b000100, 1'b0, 0, 3, 32'h00000810, 6'b001000, 1'b1};
    rows[3] = '{6'b000011, 1'b0, 0, 3, 32'h00000B10, 6'b110110, 1'b1};
    rows[4] = '{6'b000010, 1'b0, 0, 3, 32'h00000B10, 6'b110000, 1'b1};
    rows[5] = '{6'b101011, 1'b0, 3, 7, 32'h05555210, 6'b000000, 1'b1};
    rows[6] = '{6'b000000, 1'b0, 0, 4, 32'h00007610, 6'b000010, 1'b1};
    rows[7] = '{6'b001000, 1'b0, 0, 4, 32'h0000A910, 6'b000010, 1'b1};
    rows[8] = '{6'b111111, 1'b0, 0, 2, 32'h00000010, 6'b000001, 1'b0};
    ops = '{6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b000011, 6'b100011,
            6'b101011, 6'b111111, 6'b000001, 6'b001001, 6'b100000};

    // Reset state.
    do_reset();
    drive(1'b0, 1'b0, 6'b000000);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd1);
    chk("rst_ir_we", 64'(ir_we), 64'd0);
    chk("rst_pc_we", 64'(pc_we), 64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    chk_cnt();

    // Directed vector table.
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < rows[r].len; c++) begin
        logic [31:0] tr;
        tr = rows[r].trace;
        drive(!((c >= 3) && (c < 3 + rows[r].mw)), rows[r].z, rows[r].op);
        chk($sformatf("row%0d_state%0d", r, c), 64'(state), 64'(tr[4*c +: 4]));
        if (c == rows[r].len - 1)
          chk($sformatf("row%0d_last", r), 64'({pc_we, pc_src, jal, we_reg, illegal}),
              64'(rows[r].last));
        advance();
      end
      if (rows[r].ret) exp_instr++;
      chk_cnt();
    end
    drive(1'b0, 1'b0, 6'b000000);
    chk("table_state_end", 64'(state), 64'd0);
    chk("sw_boundary_mem_err", 64'(mem_err), 64'd0);

    // FETCH timeout: four wait cycles raise the sticky error, no IR load.
    do_reset();
    for (int i = 0; i < TO; i++) begin
      drive(1'b0, 1'b0, 6'b100011);
      chk("tmo_state", 64'(state), 64'd0);
      chk("tmo_ir_we", 64'(ir_we), 64'd0);
      chk("tmo_err_early", 64'(mem_err), 64'd0);
      advance();
    end
    drive(1'b0, 1'b0, 6'b100011);
    chk("tmo_mem_err", 64'(mem_err), 64'd1);
    chk("tmo_state_after", 64'(state), 64'd0);
    do_reset();
    drive(1'b0, 1'b0, 6'b100011);
    chk("tmo_rst_clears", 64'(mem_err), 64'd0);

    // Asynchronous reset while in MEMRD.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 6'b100011);
      advance();
    end
    drive(1'b0, 1'b0, 6'b100011);
    chk("memrd_reached", 64'(state), 64'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_state", 64'(state), 64'd0);
    chk("async_rst_we_reg", 64'(we_reg), 64'd0);
    do_reset();
    drive(1'b1, 1'b0, 6'b100011);
    chk("post_rst_state", 64'(state), 64'd0);
    advance();
    drive(1'b1, 1'b0, 6'b100011);
    chk("post_rst_decode", 64'(state), 64'd1);

    // Random instruction stream against the trace model.
    do_reset();
    for (int k = 0; k < 150; k++) begin
      int wf, wm;
      wf = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 2));
      wm = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
      build_instr(ops[$urandom_range(0, 10)], 1'($urandom_range(0, 1)), wf, wm);
    end
    while (tq.size() > 0) begin
      cyc_t c;
      c = tq.pop_front();
      drive(c.rdy, c.z, c.op);
      chk("rand_obs", 64'(dut_obs()), 64'(c.exp));
      chk("rand_mem_err", 64'(mem_err), 64'(exp_err));
      chk_cnt();
      advance();
      if (c.ret) exp_instr++;
      if (c.tmo) exp_err = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
